// File: rtl/call_stack.sv
// -----------------------------------------------------------------------------
// call_stack
// Return-address stack for the 19-bit core. CALL and RET are decoded from the
// same types/opcode fields the branch unit sees, in the same cycle. The
// subroutine_pc_next/subroutine_pc_src outputs are combinational so the branch
// unit can redirect with zero latency. The push or pop commits on the next
// rising clock edge.
//
// Optional feature macro: CALLSTACK_CIRCULAR_EN
//   defined   : a CALL on a full stack is taken and overwrites the oldest entry.
//               depth stays at DEPTH.
//   undefined : a CALL on a full stack is refused (default).
//   In both builds a CALL on a full stack sets the sticky stack_overflow flag.
//
// Ports
//   clk                in   clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   types              in   instruction type field
//   opcode             in   instruction opcode field
//   pc_current         in   PC of the instruction being decoded
//   call_addr          in   CALL target field, zero-extended to PC_W
//   program_end        in   program halted; suppresses every action
//   subroutine_pc_next out  CALL target or popped return address
//   subroutine_pc_src  out  1 = branch unit must take subroutine_pc_next
//   depth              out  number of valid entries held
//   stack_overflow     out  sticky: a CALL was issued while the stack was full
//   stack_underflow    out  sticky: a RET was issued while the stack was empty
// -----------------------------------------------------------------------------
module call_stack #(
  parameter int PC_W    = 19,
  parameter int JADDR_W = 11,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 types,
  input  logic [3:0]                 opcode,
  input  logic [PC_W-1:0]            pc_current,
  input  logic [JADDR_W-1:0]         call_addr,
  input  logic                       program_end,
  output logic [PC_W-1:0]            subroutine_pc_next,
  output logic                       subroutine_pc_src,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       stack_overflow,
  output logic                       stack_underflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int DEPTH_W = $clog2(DEPTH+1);
  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]   PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]    PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};

  // Instruction decode helpers.
  function automatic logic f_is_call(input logic [1:0] t, input logic [3:0] op);
    return (t == 2'b10) && (op == 4'b0101);
  endfunction

  function automatic logic f_is_ret(input logic [1:0] t, input logic [3:0] op);
    return (t == 2'b10) && (op == 4'b0110);
  endfunction

  logic [PC_W-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0]   r_ptr;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_call;
  logic               w_ret;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [PTR_W-1:0]   w_ptr_inc;

  // Decode and qualify the push/pop requests for this cycle.
  always_comb begin
    w_call    = f_is_call(types, opcode) && !program_end;
    w_ret     = f_is_ret(types, opcode) && !program_end;
    w_full    = (r_depth == DEPTH_FULL);
    w_empty   = (r_depth == {DEPTH_W{1'b0}});
    w_ptr_inc = r_ptr + PTR_ONE;
`ifdef CALLSTACK_CIRCULAR_EN
    // A full stack still accepts the CALL; the oldest slot is reused.
    w_push    = w_call;
`else
    w_push    = w_call && !w_full;
`endif
    w_pop     = w_ret && !w_empty;
  end

  // Redirect outputs. They are forced to zero while reset is held so that the
  // branch unit never sees a stale entry.
  always_comb begin
    subroutine_pc_src  = 1'b0;
    subroutine_pc_next = {PC_W{1'b0}};
    if (!rst_n) begin
      subroutine_pc_src  = 1'b0;
      subroutine_pc_next = {PC_W{1'b0}};
    end else if (w_push) begin
      subroutine_pc_src  = 1'b1;
      subroutine_pc_next = {{(PC_W-JADDR_W){1'b0}}, call_addr};
    end else if (w_pop) begin
      subroutine_pc_src  = 1'b1;
      subroutine_pc_next = r_mem[r_ptr];
    end else begin
      subroutine_pc_src  = 1'b0;
      subroutine_pc_next = {PC_W{1'b0}};
    end
  end

  // Pointer, depth and sticky flag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= {PTR_W{1'b0}};
      r_depth     <= {DEPTH_W{1'b0}};
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          r_ptr <= w_ptr_inc;
          // When a circular push lands on a full stack, depth saturates.
          if (!w_full) begin
            r_depth <= r_depth + DEPTH_ONE;
          end else begin
            r_depth <= r_depth;
          end
        end
        2'b01: begin
          r_ptr   <= r_ptr - PTR_ONE;
          r_depth <= r_depth - DEPTH_ONE;
        end
        default: begin
          r_ptr   <= r_ptr;
          r_depth <= r_depth;
        end
      endcase
      if (w_call && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_ret && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Entry storage. The contents are not reset; depth alone marks valid entries.
  always_ff @(posedge clk) begin
    if (w_push && rst_n) begin
      r_mem[w_ptr_inc] <= pc_current + PC_ONE;
    end
  end

  assign depth           = r_depth;
  assign stack_overflow  = r_overflow;
  assign stack_underflow = r_underflow;

endmodule

// File: tb/tb_call_stack.sv
module tb_call_stack;

  logic        clk;
  logic        rst_n;
  logic [1:0]  types;
  logic [3:0]  opcode;
  logic [18:0] pc_current;
  logic [10:0] call_addr;
  logic        program_end;
  logic [18:0] subroutine_pc_next;
  logic        subroutine_pc_src;
  logic [3:0]  depth;
  logic        stack_overflow;
  logic        stack_underflow;

  int n_checks = 0;
  int n_err    = 0;

  call_stack dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .types              (types),
    .opcode             (opcode),
    .pc_current         (pc_current),
    .call_addr          (call_addr),
    .program_end        (program_end),
    .subroutine_pc_next (subroutine_pc_next),
    .subroutine_pc_src  (subroutine_pc_src),
    .depth              (depth),
    .stack_overflow     (stack_overflow),
    .stack_underflow    (stack_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    types       = 2'b00;
    opcode      = 4'b0000;
    program_end = 1'b0;
  endtask

  // Apply a CALL, check the redirect, then let it commit.
  task automatic do_call(input string tag, input logic [18:0] pc, input logic [10:0] addr,
                         input logic exp_src);
    types      = 2'b10;
    opcode     = 4'b0101;
    pc_current = pc;
    call_addr  = addr;
    #2;
    check({tag, "_src"}, 32'(subroutine_pc_src), 32'(exp_src));
    check({tag, "_next"}, 32'(subroutine_pc_next), exp_src ? 32'(addr) : 32'h0);
    @(posedge clk); #1;
    idle();
  endtask

  // Apply a RET, check the redirect, then let it commit.
  task automatic do_ret(input string tag, input logic exp_src, input logic [18:0] exp_next);
    types  = 2'b10;
    opcode = 4'b0110;
    #2;
    check({tag, "_src"}, 32'(subroutine_pc_src), 32'(exp_src));
    check({tag, "_next"}, 32'(subroutine_pc_next), 32'(exp_next));
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    rst_n      = 1'b0;
    pc_current = 19'h0;
    call_addr  = 11'h0;
    idle();
    // A CALL during reset must not redirect.
    types = 2'b10; opcode = 4'b0101; call_addr = 11'h55;
    #3;
    check("rst_src", 32'(subroutine_pc_src), 32'h0);
    check("rst_next", 32'(subroutine_pc_next), 32'h0);
    check("rst_depth", 32'(depth), 32'h0);
    check("rst_ovf", 32'(stack_overflow), 32'h0);
    check("rst_unf", 32'(stack_underflow), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    idle();
    rst_n = 1'b1;
    check("rst_depth_post", 32'(depth), 32'h0);

    // Test 1: single CALL/RET.
    do_call("t1_call", 19'h00010, 11'h123, 1'b1);
    check("t1_depth1", 32'(depth), 32'h1);
    do_ret("t1_ret", 1'b1, 19'h00011);
    check("t1_depth0", 32'(depth), 32'h0);

    // JMP and branch are not stack operations.
    types = 2'b10; opcode = 4'b0011; #2;
    check("jmp_src", 32'(subroutine_pc_src), 32'h0);
    types = 2'b11; opcode = 4'b0101; #2;
    check("br_src", 32'(subroutine_pc_src), 32'h0);
    @(posedge clk); #1; idle();
    check("jmp_depth", 32'(depth), 32'h0);

    // Test 2: nested.
    do_call("t2_c1", 19'h10, 11'h100, 1'b1);
    do_call("t2_c2", 19'h20, 11'h200, 1'b1);
    do_call("t2_c3", 19'h30, 11'h300, 1'b1);
    check("t2_depth3", 32'(depth), 32'h3);
    do_ret("t2_r1", 1'b1, 19'h31);
    do_ret("t2_r2", 1'b1, 19'h21);
    do_ret("t2_r3", 1'b1, 19'h11);
    check("t2_depth0", 32'(depth), 32'h0);

    // Test 3: underflow.
    do_ret("t3_empty", 1'b0, 19'h0);
    check("t3_unf", 32'(stack_underflow), 32'h1);
    check("t3_depth", 32'(depth), 32'h0);
    do_call("t3_call", 19'h40, 11'h7FF, 1'b1);
    do_ret("t3_ret", 1'b1, 19'h41);
    check("t3_unf_sticky", 32'(stack_underflow), 32'h1);

    // Test 4: fill past capacity.
    for (int i = 1; i <= 8; i++) begin
      do_call($sformatf("t4_c%0d", i), 19'(i * 32'h100), 11'(i), 1'b1);
    end
    check("t4_full_depth", 32'(depth), 32'h8);
    check("t4_ovf_pre", 32'(stack_overflow), 32'h0);
`ifdef CALLSTACK_CIRCULAR_EN
    do_call("t4_c9", 19'h900, 11'h9, 1'b1);
`else
    do_call("t4_c9", 19'h900, 11'h9, 1'b0);
`endif
    check("t4_ovf", 32'(stack_overflow), 32'h1);
    check("t4_depth_sat", 32'(depth), 32'h8);
    for (int i = 0; i < 8; i++) begin
`ifdef CALLSTACK_CIRCULAR_EN
      do_ret($sformatf("t4_r%0d", i), 1'b1, 19'((9 - i) * 32'h100 + 32'h1));
`else
      do_ret($sformatf("t4_r%0d", i), 1'b1, 19'((8 - i) * 32'h100 + 32'h1));
`endif
    end
    check("t4_depth0", 32'(depth), 32'h0);

    // Test 5: PC wrap and program_end.
    do_call("t5_wrap", 19'h7FFFF, 11'h001, 1'b1);
    do_ret("t5_wrap_ret", 1'b1, 19'h00000);
    program_end = 1'b1;
    types = 2'b10; opcode = 4'b0101; call_addr = 11'h222; #2;
    check("t5_pe_src", 32'(subroutine_pc_src), 32'h0);
    check("t5_pe_next", 32'(subroutine_pc_next), 32'h0);
    @(posedge clk); #1; idle();
    check("t5_pe_depth", 32'(depth), 32'h0);

    // Test 6: reset between a CALL's decode and its edge.
    do_call("t6_pre", 19'h50, 11'h050, 1'b1);
    types = 2'b10; opcode = 4'b0101; pc_current = 19'h60; call_addr = 11'h060; #2;
    check("t6_src_before", 32'(subroutine_pc_src), 32'h1);
    check("t6_depth_before", 32'(depth), 32'h1);
    rst_n = 1'b0; #1;
    check("t6_depth", 32'(depth), 32'h0);
    check("t6_src", 32'(subroutine_pc_src), 32'h0);
    check("t6_next", 32'(subroutine_pc_next), 32'h0);
    check("t6_ovf", 32'(stack_overflow), 32'h0);
    check("t6_unf", 32'(stack_underflow), 32'h0);
    @(posedge clk); #1;
    check("t6_depth_edge", 32'(depth), 32'h0);
    idle();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_depth_after", 32'(depth), 32'h0);
    do_ret("t6_ret_empty", 1'b0, 19'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
